alu_issue_ctrl: RTL and testbench

//  Sequencer directly upstream of the 4-bit combinational ALU. Queues {opcode,A,B} commands,

---
 rtl/alu_issue_ctrl_if.sv | 50 +++++
 rtl/alu_issue_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Command / ALU / response bundle between the issue controller and its
// surroundings. The slave modport is the controller's view; the master
// modport is the view of whatever feeds commands, hosts the ALU and
// consumes responses.
interface alu_issue_ctrl_if #(
  parameter int W   = 4,
  parameter int OPW = 4
);
  // Command port
  logic           cmd_valid;
  logic           cmd_ready;
  logic [OPW-1:0] cmd_opcode;
  logic [W-1:0]   cmd_a;
  logic [W-1:0]   cmd_b;
  logic           cmd_use_acc;

  // Registered operand lines to the combinational ALU and its outputs
  logic [OPW-1:0] alu_opcode;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [W-1:0]   alu_result;
  logic           alu_carry;
  logic           alu_zero;

  // Response port
  logic           rsp_valid;
  logic           rsp_ready;
  logic [OPW-1:0] rsp_opcode;
  logic [W-1:0]   rsp_result;
  logic           rsp_carry;
  logic           rsp_zero;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_use_acc,
    output cmd_ready,
    output alu_opcode, alu_a, alu_b,
    input  alu_result, alu_carry, alu_zero,
    output rsp_valid, rsp_opcode, rsp_result, rsp_carry, rsp_zero,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_use_acc,
    input  cmd_ready,
    input  alu_opcode, alu_a, alu_b,
    output alu_result, alu_carry, alu_zero,
    input  rsp_valid, rsp_opcode, rsp_result, rsp_carry, rsp_zero,
    output rsp_ready
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for a 4-bit combinational ALU. Commands are queued in a
// small FIFO, dispatched one at a time onto registered operand lines, and
// the ALU outputs are captured one cycle later into a held response plus an
// accumulator that later commands may use as operand A.
module alu_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int W     = 4,
  parameter int OPW   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  alu_issue_ctrl_if.slave         bus,
  output logic [W-1:0]            acc,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [OPW-1:0] opcode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           use_acc;
  } cmd_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  logic [OPW-1:0] alu_opcode_q, alu_opcode_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;

  logic           rsp_valid_q, rsp_valid_d;
  logic [OPW-1:0] rsp_opcode_q, rsp_opcode_d;
  logic [W-1:0]   rsp_result_q, rsp_result_d;
  logic           rsp_carry_q, rsp_carry_d;
  logic           rsp_zero_q, rsp_zero_d;
  logic [W-1:0]   acc_q, acc_d;

  cmd_t           fifo_mem [DEPTH];
  cmd_t           wr_cmd;
  cmd_t           head;

  logic           push;
  logic           pop;
  logic           capture;
  logic           rsp_clear;

  // Flush blocks new commands in the same cycle it drops the queue.
  assign bus.cmd_ready = !flush && (count_q < CW'(DEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready;

  assign wr_cmd = '{opcode:  bus.cmd_opcode,
                    a:       bus.cmd_a,
                    b:       bus.cmd_b,
                    use_acc: bus.cmd_use_acc};
  assign head   = fifo_mem[rd_ptr_q];

  // Command storage; written on push only.
  // NOTE: the FIFO array has no reset -- only pointers and count define which
  // entries are live, so resetting the storage would add logic for nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= wr_cmd;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control strobes: when to pop, capture and retire a response.
  // NOTE: every signal is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    capture   = 1'b0;
    rsp_clear = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = EXEC;
          end
        end
        EXEC: begin
          capture = 1'b1;
          state_d = RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_clear = 1'b1;
            if (count_q != '0) begin
              pop     = 1'b1;
              state_d = EXEC;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next values: FIFO bookkeeping, dispatch onto the ALU lines,
  // and capture of the ALU outputs into the response and accumulator.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_opcode_d = rsp_opcode_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
    acc_d        = acc_q;

    if (flush) begin
      // Queue and pending response are dropped; acc and ALU lines are kept.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      rsp_valid_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d     = rd_ptr_q + AW'(1);
        alu_opcode_d = head.opcode;
        alu_a_d      = head.use_acc ? acc_q : head.a;
        alu_b_d      = head.b;
      end
      count_d = count_q + CW'(push) - CW'(pop);

      if (capture) begin
        rsp_valid_d  = 1'b1;
        rsp_opcode_d = alu_opcode_q;
        rsp_result_d = bus.alu_result;
        rsp_carry_d  = bus.alu_carry;
        rsp_zero_d   = bus.alu_zero;
        acc_d        = bus.alu_result;
      end else if (rsp_clear) begin
        rsp_valid_d = 1'b0;
      end
    end
  end

  // State registers for pointers, operand lines, response and accumulator.
  // NOTE: non-blocking assignments here so every register samples the values
  // from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_opcode_q <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      acc_q        <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_opcode_q <= rsp_opcode_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
      acc_q        <= acc_d;
    end
  end

  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_opcode = rsp_opcode_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign acc            = acc_q;
  assign count          = count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: hosts a small 4-bit ALU model on the operand
// lines, issues directed commands with hand-computed expected responses into
// a scoreboard queue, and a monitor pops and compares on each response
// handshake.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [3:0] acc;
  logic [2:0] count;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave),
    .acc   (acc),
    .count (count)
  );

  always #5 clk = ~clk;

  // ALU model: 0 ADD, 1 SUB (carry=borrow), 2 AND, 3 OR, 4 XOR, 5 MUL,
  // 6 DIV (b=0 -> result 0, carry 1), anything else -> 0.
  logic [3:0] alu_res;
  logic       alu_car;
  logic [7:0] alu_prod;

  always_comb begin
    alu_res  = 4'd0;
    alu_car  = 1'b0;
    alu_prod = {4'd0, bus.alu_a} * {4'd0, bus.alu_b};
    case (bus.alu_opcode)
      4'd0: {alu_car, alu_res} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      4'd1: begin
        alu_res = bus.alu_a - bus.alu_b;
        alu_car = bus.alu_a < bus.alu_b;
      end
      4'd2: alu_res = bus.alu_a & bus.alu_b;
      4'd3: alu_res = bus.alu_a | bus.alu_b;
      4'd4: alu_res = bus.alu_a ^ bus.alu_b;
      4'd5: begin
        alu_res = alu_prod[3:0];
        alu_car = |alu_prod[7:4];
      end
      4'd6: begin
        if (bus.alu_b == 4'd0) begin
          alu_res = 4'd0;
          alu_car = 1'b1;
        end else begin
          alu_res = bus.alu_a / bus.alu_b;
        end
      end
      default: ;
    endcase
  end

  assign bus.alu_result = alu_res;
  assign bus.alu_carry  = alu_car;
  assign bus.alu_zero   = (alu_res == 4'd0);

  typedef struct {
    logic [3:0] op;
    logic [3:0] res;
    logic       c;
    logic       z;
  } exp_t;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   rsp_mode = 0;  // 0: ready low, 1: ready high, 2: random

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // rsp_ready driver, changes just after each rising edge.
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rsp_mode)
        0:       bus.rsp_ready = 1'b0;
        1:       bus.rsp_ready = 1'b1;
        default: bus.rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: a handshake seen at the falling edge completes at the next rise.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 8'd1, 8'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_opcode", bus.rsp_opcode, mon_e.op);
        check("rsp_result", bus.rsp_result, mon_e.res);
        check("rsp_carry",  bus.rsp_carry,  mon_e.c);
        check("rsp_zero",   bus.rsp_zero,   mon_e.z);
      end
    end
  end

  // Offer one command and wait (bounded) for it to be accepted.
  task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic ua, input bit track,
                      input logic [3:0] r, input logic c, input logic z);
    bit ok;
    if (track) sb.push_back('{op, r, c, z});
    bus.cmd_valid   = 1'b1;
    bus.cmd_opcode  = op;
    bus.cmd_a       = a;
    bus.cmd_b       = b;
    bus.cmd_use_acc = ua;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) ok = 1'b1;
      @(posedge clk);
    end
    #1;
    bus.cmd_valid = 1'b0;
    if (!ok) check("cmd_accept_timeout", 8'd0, 8'd1);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    check(name, 8'(sb.size()), 8'd0);
  endtask

  task automatic set_rsp_mode(input int m);
    rsp_mode = m;
    @(posedge clk);
    #2;
  endtask

  initial begin
    bit hit;
    rst_n           = 1'b0;
    flush           = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_opcode  = '0;
    bus.cmd_a       = '0;
    bus.cmd_b       = '0;
    bus.cmd_use_acc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("reset_rsp_valid",  bus.rsp_valid,  8'd0);
    check("reset_count",      count,          8'd0);
    check("reset_acc",        acc,            8'd0);
    check("reset_alu_a",      bus.alu_a,      8'd0);
    check("reset_alu_opcode", bus.alu_opcode, 8'd0);
    check("reset_cmd_ready",  bus.cmd_ready,  8'd1);

    // 1: ADD 9+8 latency and result
    set_rsp_mode(1);
    send(4'd0, 4'd9, 4'd8, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
    check("t1_valid_edge0", bus.rsp_valid, 8'd0);
    @(posedge clk); #1;
    check("t1_valid_edge1", bus.rsp_valid, 8'd0);
    check("t1_alu_a", bus.alu_a, 8'd9);
    check("t1_alu_b", bus.alu_b, 8'd8);
    @(posedge clk); #1;
    check("t1_valid_edge2", bus.rsp_valid, 8'd1);
    check("t1_acc", acc, 8'd1);
    wait_drain("t1_drain");

    // 2: ADD 3+4, then SUB acc-7 back to back
    send(4'd0, 4'd3, 4'd4, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
    send(4'd1, 4'hF, 4'd7, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
    wait_drain("t2_drain");

    // 3: back-pressure: 5 accepted, 6th refused
    set_rsp_mode(0);
    send(4'd0, 4'd1,  4'd2,  1'b0, 1'b1, 4'd3,  1'b0, 1'b0);
    send(4'd1, 4'd5,  4'd9,  1'b0, 1'b1, 4'hC,  1'b1, 1'b0);
    send(4'd2, 4'hC,  4'hA,  1'b0, 1'b1, 4'd8,  1'b0, 1'b0);
    send(4'd3, 4'd0,  4'd1,  1'b1, 1'b1, 4'd9,  1'b0, 1'b0);
    send(4'd4, 4'hF,  4'hF,  1'b0, 1'b1, 4'd0,  1'b0, 1'b1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_opcode  = 4'd0;
    bus.cmd_a       = 4'd1;
    bus.cmd_b       = 4'd1;
    bus.cmd_use_acc = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t3_full_cmd_ready", bus.cmd_ready, 8'd0);
      check("t3_full_count", count, 8'd4);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    set_rsp_mode(1);
    wait_drain("t3_drain");

    // 4: 11 mixed commands with random back-pressure
    set_rsp_mode(2);
    send(4'd0, 4'd7,  4'd5,  1'b0, 1'b1, 4'd12, 1'b0, 1'b0);
    send(4'd1, 4'hF,  4'd3,  1'b1, 1'b1, 4'd9,  1'b0, 1'b0);
    send(4'd5, 4'd3,  4'd6,  1'b0, 1'b1, 4'd2,  1'b1, 1'b0);
    send(4'd0, 4'hA,  4'hF,  1'b1, 1'b1, 4'd1,  1'b1, 1'b0);
    send(4'd4, 4'hA,  4'd5,  1'b0, 1'b1, 4'hF,  1'b0, 1'b0);
    send(4'd6, 4'hE,  4'd3,  1'b0, 1'b1, 4'd4,  1'b0, 1'b0);
    send(4'd1, 4'd0,  4'd9,  1'b1, 1'b1, 4'hB,  1'b1, 1'b0);
    send(4'd2, 4'hF,  4'd4,  1'b1, 1'b1, 4'd0,  1'b0, 1'b1);
    send(4'd3, 4'd0,  4'd0,  1'b0, 1'b1, 4'd0,  1'b0, 1'b1);
    send(4'd6, 4'd9,  4'd2,  1'b0, 1'b1, 4'd4,  1'b0, 1'b0);
    send(4'd0, 4'd1,  4'hC,  1'b1, 1'b1, 4'd0,  1'b1, 1'b1);
    set_rsp_mode(1);
    wait_drain("t4_drain");
    check("t4_acc", acc, 8'd0);

    // 5: divide by zero and an undefined opcode pass through
    send(4'd6,  4'd5, 4'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
    send(4'hD,  4'd3, 4'd2, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    wait_drain("t5_drain");

    // 6: flush while holding a response with two queued
    set_rsp_mode(0);
    send(4'd0, 4'd2, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    send(4'd0, 4'd1, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    send(4'd0, 4'd1, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (bus.rsp_valid && count == 3'd2) hit = 1'b1;
    end
    check("t6_reached_resp", 8'(hit), 8'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    #1;
    check("t6_flush_cmd_ready", bus.cmd_ready, 8'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("t6_rsp_valid", bus.rsp_valid, 8'd0);
    check("t6_count",     count,         8'd0);
    check("t6_cmd_ready", bus.cmd_ready, 8'd1);
    check("t6_acc",       acc,           8'd5);

    // Asynchronous reset while an op is in EXEC
    set_rsp_mode(1);
    send(4'd0, 4'd9, 4'd9, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("rst_pre_alu_a", bus.alu_a, 8'd9);
    rst_n = 1'b0;
    #1;
    check("rst_alu_opcode", bus.alu_opcode, 8'd0);
    check("rst_alu_a",      bus.alu_a,      8'd0);
    check("rst_alu_b",      bus.alu_b,      8'd0);
    check("rst_rsp_valid",  bus.rsp_valid,  8'd0);
    check("rst_acc",        acc,            8'd0);
    check("rst_count",      count,          8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 8'd1);
    repeat (3) @(posedge clk);
    #1;
    check("final_sb_empty", 8'(sb.size()), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
